// File: rtl/epcs_pkg.sv
// epcs_pkg: shared constants and types for the EPCS TX interface.
//   K28_5_RDN / K28_5_RDP : 10-bit K28.5 comma codes, both running disparities
//   IDLE_WORD_DEF         : default 20-bit idle word {K28.5 RD+, K28.5 RD-}
//   state_t               : TX control state encoding
package epcs_pkg;

    localparam int          WORD_W        = 20;
    localparam logic [9:0]  K28_5_RDN     = 10'h0FA;
    localparam logic [9:0]  K28_5_RDP     = 10'h305;
    localparam logic [19:0] IDLE_WORD_DEF = {K28_5_RDP, K28_5_RDN};

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/epcs_tx_fifo.sv
// epcs_tx_fifo: synchronous FIFO with first-word-fall-through read data.
//   clk, rstn : clock, asynchronous active-low reset of pointers/count
//   push      : write din (ignored when full)
//   pop       : advance the read pointer (ignored when empty)
//   flush     : synchronous clear of pointers and count; wins over push/pop
//   din       : write data
//   dout      : word at the read pointer (valid whenever count != 0)
//   count     : number of stored words, 0..FIFO_DEPTH
module epcs_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 20
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count < DEPTH_C);
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count are control.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are power-of-two wide, so increment wraps modulo depth.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/epcs_tx_intf.sv
// epcs_tx_intf: fabric-to-EPCS lane TX interface.
// Buffers 20-bit pre-encoded words, sends an ALIGN_CYCLES comma burst after
// each lane_rdy rise, then streams data (idle commas fill gaps) through a
// two-register retiming path.
//   clk       : transmit word clock
//   rstn      : asynchronous active-low reset
//   lane_rdy  : SerDes TX lane ready
//   txdin     : word to transmit       txvali : txdin valid
//   txrdy     : FIFO accepts a word this cycle
//   txdout    : word to EPCS TX port   txvalo : txdout is data, not idle
//   aligned   : alignment burst done, data path live
//   err_wr    : sticky, txvali seen while txrdy low (word dropped)
// Build option EPCS_TX_NEGEDGE_EN: adds a negedge register on txdout/txvalo
// for half-cycle hold margin at the SerDes input.
module epcs_tx_intf
    import epcs_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          ALIGN_CYCLES = 16,
    parameter logic [19:0] IDLE_WORD    = IDLE_WORD_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lane_rdy,
    input  logic [19:0] txdin,
    input  logic        txvali,
    output logic        txrdy,
    output logic [19:0] txdout,
    output logic        txvalo,
    output logic        aligned,
    output logic        err_wr
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  ALIGN_END = 8'(ALIGN_CYCLES - 1);

    state_t       state;
    state_t       next_state;
    logic [7:0]   align_cnt;
    logic [AW:0]  count;
    logic [19:0]  fifo_dout;
    logic         push;
    logic         pop;
    logic         flush;

    logic [19:0]  stage1_p1;
    logic         vld_p1;
    logic [19:0]  dout_p2;
    logic         vld_p2;

    assign txrdy = (state != WAIT) && (count < DEPTH_C);
    assign push  = txvali && txrdy;
    // Pop is held off on the edge that drops into WAIT so no queued word
    // leaks into the pipeline while the FIFO is being flushed.
    assign pop   = (state == RUN) && lane_rdy && (count != '0);
    assign flush = !lane_rdy || (state == WAIT);

    epcs_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (20)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (txdin),
        .dout  (fifo_dout),
        .count (count)
    );

    always_comb begin
        next_state = state;
        case (state)
            WAIT:    if (lane_rdy) next_state = ALIGN;
            ALIGN:   if (align_cnt == ALIGN_END) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = WAIT;
        endcase
        if (!lane_rdy) begin
            next_state = WAIT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= WAIT;
            align_cnt <= '0;
            aligned   <= 1'b0;
            err_wr    <= 1'b0;
        end else begin
            state     <= next_state;
            align_cnt <= (state == ALIGN) ? align_cnt + 1'b1 : 8'd0;
            aligned   <= (state == RUN);
            err_wr    <= err_wr | (txvali & ~txrdy);
        end
    end

    // ---- stage p1: FIFO head or idle comma ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage1_p1 <= '0;
            vld_p1    <= 1'b0;
        end else if (pop) begin
            stage1_p1 <= fifo_dout;
            vld_p1    <= 1'b1;
        end else begin
            stage1_p1 <= IDLE_WORD;
            vld_p1    <= 1'b0;
        end
    end

    // ---- stage p2: posedge output register ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_p2 <= '0;
            vld_p2  <= 1'b0;
        end else begin
            dout_p2 <= stage1_p1;
            vld_p2  <= vld_p1;
        end
    end

`ifdef EPCS_TX_NEGEDGE_EN
    logic [19:0] dout_p3;
    logic        vld_p3;

    // ---- stage p3: negedge retiming for SerDes hold margin ----
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_p3 <= '0;
            vld_p3  <= 1'b0;
        end else begin
            dout_p3 <= dout_p2;
            vld_p3  <= vld_p2;
        end
    end

    assign txdout = dout_p3;
    assign txvalo = vld_p3;
`else
    assign txdout = dout_p2;
    assign txvalo = vld_p2;
`endif

endmodule

// File: tb/tb_epcs_tx_intf.sv
// tb_epcs_tx_intf: directed bench for epcs_tx_intf (FIFO_DEPTH=4,
// ALIGN_CYCLES=16): reset state, alignment burst, single-word latency,
// lane drop with queued words, burst with overflow error, async reset.
module tb_epcs_tx_intf;

    localparam logic [19:0] IDLE = 20'hC14FA;

    logic        clk;
    logic        rstn;
    logic        lane_rdy;
    logic [19:0] txdin;
    logic        txvali;
    logic        txrdy;
    logic [19:0] txdout;
    logic        txvalo;
    logic        aligned;
    logic        err_wr;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [19:0] words [10];

    epcs_tx_intf #(
        .FIFO_DEPTH   (4),
        .ALIGN_CYCLES (16),
        .IDLE_WORD    (20'hC14FA)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .lane_rdy (lane_rdy),
        .txdin    (txdin),
        .txvali   (txvali),
        .txrdy    (txrdy),
        .txdout   (txdout),
        .txvalo   (txvalo),
        .aligned  (aligned),
        .err_wr   (err_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
`ifdef EPCS_TX_NEGEDGE_EN
        @(negedge clk);
        #1;
`endif
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk20(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            words[i] = 20'hB0000 + 20'(i * 17 + 3);
        end
        rstn     = 1'b0;
        lane_rdy = 1'b1;
        txvali   = 1'b0;
        txdin    = '0;

        // Reset state
        step();
        step();
        chk20("rst_txdout", txdout, 20'd0);
        chk1("rst_txvalo", txvalo, 1'b0);
        chk1("rst_aligned", aligned, 1'b0);
        chk1("rst_txrdy", txrdy, 1'b0);
        chk1("rst_err_wr", err_wr, 1'b0);

        // Release reset; lane_rdy already high, first sampled at edge M
        rstn = 1'b1;
        step();
        chk20("first_edge_txdout", txdout, 20'd0);
        chk1("align_txrdy", txrdy, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk20("align_txdout", txdout, IDLE);
            chk1("align_txvalo", txvalo, 1'b0);
            chk1("align_aligned", aligned, (k >= 17));
        end

        // Single word in RUN, accepted at edge N
        txdin  = 20'h12345;
        txvali = 1'b1;
        step();
        txvali = 1'b0;
        chk1("single_n0_txvalo", txvalo, 1'b0);
        step();
        chk20("single_n1_txdout", txdout, IDLE);
        chk1("single_n1_txvalo", txvalo, 1'b0);
        step();
        chk20("single_n2_txdout", txdout, 20'h12345);
        chk1("single_n2_txvalo", txvalo, 1'b1);
        step();
        chk20("single_n3_txdout", txdout, IDLE);
        chk1("single_n3_txvalo", txvalo, 1'b0);
        chk1("single_err_wr", err_wr, 1'b0);

        // Lane drop from RUN
        lane_rdy = 1'b0;
        step();
        chk1("drop_txrdy", txrdy, 1'b0);
        step();
        chk1("drop_aligned", aligned, 1'b0);

        // Realign, pre-fill 3 words, drop lane on the first RUN edge
        lane_rdy = 1'b1;
        step();
        chk1("realign_txrdy", txrdy, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            if (k <= 3) begin
                txvali = 1'b1;
                txdin  = 20'h0AAA0 + 20'(k);
            end else begin
                txvali = 1'b0;
            end
            step();
            if (k <= 3) chk1("prefill_txrdy", txrdy, 1'b1);
            chk1("prefill_txvalo", txvalo, 1'b0);
        end
        lane_rdy = 1'b0;
        step();
        chk1("queued_drop_txrdy", txrdy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("queued_lost_txvalo", txvalo, 1'b0);
            chk20("queued_lost_txdout", txdout, IDLE);
        end
        chk1("queued_err_wr", err_wr, 1'b0);

        // Realign with a 10-word burst while pop is stalled
        lane_rdy = 1'b1;
        step();
        for (int k = 1; k <= 22; k++) begin
            if (k <= 10) begin
                txvali = 1'b1;
                txdin  = words[k-1];
            end else begin
                txvali = 1'b0;
            end
            step();
            if (k <= 10) chk1("burst_txrdy", txrdy, (k < 4));
            if (k == 4) chk1("burst_err_before", err_wr, 1'b0);
            if (k == 5) chk1("burst_err_after", err_wr, 1'b1);
            if (k <= 17) begin
                chk1("burst_no_early_txvalo", txvalo, 1'b0);
                chk1("burst_aligned", aligned, (k >= 17));
            end
            if (k >= 18 && k <= 21) begin
                chk20("burst_out_txdout", txdout, words[k-18]);
                chk1("burst_out_txvalo", txvalo, 1'b1);
            end
            if (k == 22) begin
                chk20("burst_end_txdout", txdout, IDLE);
                chk1("burst_end_txvalo", txvalo, 1'b0);
            end
        end

        // Asynchronous reset mid-stream
        txdin  = 20'h55555;
        txvali = 1'b1;
        step();
        txvali = 1'b0;
        step();
        step();
        chk20("pre_rst_txdout", txdout, 20'h55555);
        chk1("pre_rst_txvalo", txvalo, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk20("async_rst_txdout", txdout, 20'd0);
        chk1("async_rst_txvalo", txvalo, 1'b0);
        chk1("async_rst_aligned", aligned, 1'b0);
        chk1("async_rst_txrdy", txrdy, 1'b0);
        chk1("async_rst_err_wr", err_wr, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
